// File: rtl/axi_order_pkg.sv
// ---------------------------------------------------------------------------
// axi_order_pkg
// Shared definitions for the AR ordering controller: FSM state encoding,
// the lock_dest value that marks "error responder" as the locked target,
// the default in-flight burst limit and a saturating increment helper.
// No ports (package).
// ---------------------------------------------------------------------------
package axi_order_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        DRAIN    = 2'd2,
        ERR_WAIT = 2'd3
    } ord_state_e;

    localparam int DEFAULT_MAX_OUTSTANDING = 8;

    // lock_dest is one-hot per target; the error responder is encoded as
    // all bits equal to this value, which coincides with the all-zero
    // decode-error destination so a simple equality compare matches it.
    localparam logic LOCK_ERROR_BIT = 1'b0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/axi_outstanding_counter.sv
// ---------------------------------------------------------------------------
// axi_outstanding_counter
// Tracks the number of in-flight read bursts. A decrement at zero is
// ignored; an increment and decrement in the same cycle cancel; an
// increment while full is only honoured when paired with a decrement.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   inc_i        one burst issued
//   dec_i        one burst completed (last R beat)
//   cnt_o        current count
//   full_o       count == MAX_OUTSTANDING
//   empty_o      count == 0
// ---------------------------------------------------------------------------
module axi_outstanding_counter
    import axi_order_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inc_eff, dec_eff;

    assign full_o  = (cnt_q == MAX_C);
    assign empty_o = (cnt_q == '0);
    assign dec_eff = dec_i & ~empty_o;
    assign inc_eff = inc_i & (~full_o | dec_eff);

    always_comb begin
        cnt_d = cnt_q;
        case ({inc_eff, dec_eff})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/axi_ar_order_ctrl.sv
// ---------------------------------------------------------------------------
// axi_ar_order_ctrl
// Keeps AXI read bursts from one master in order across target ports: new
// bursts may only go to the target (or error responder) that already has
// bursts in flight; a request to a different target waits until all
// in-flight bursts have completed.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   arvalid_i       upstream AR valid
//   dest_i          one-hot decoded target, all-zero = decode error
//   arready_o       upstream AR ready
//   arvalid_o       per-target AR valid
//   arready_i       per-target AR ready
//   error_req_o     request to the error responder
//   error_gnt_i     error responder accepts the request
//   r_done_i        last R beat handshake upstream
//   outstanding_o   in-flight burst count
//   stall_cnt_o     stalled-request cycle counter
// Build option: AXI_AR_ORDER_CTRL_STATS_EN enables the stall counter;
// otherwise stall_cnt_o is constant zero.
//
// state    | meaning
// IDLE     | nothing in flight, any request forwarded
// ACTIVE   | bursts in flight to lock_dest, matching requests forwarded
// DRAIN    | mismatching target request held until count is zero
// ERR_WAIT | decode-error request held until count is zero
// ---------------------------------------------------------------------------
module axi_ar_order_ctrl
    import axi_order_pkg::*;
#(
    parameter  int N_INIT_PORT     = 4,
    parameter  int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arvalid_i,
    input  logic [N_INIT_PORT-1:0] dest_i,
    output logic                   arready_o,
    output logic [N_INIT_PORT-1:0] arvalid_o,
    input  logic [N_INIT_PORT-1:0] arready_i,
    output logic                   error_req_o,
    input  logic                   error_gnt_i,
    input  logic                   r_done_i,
    output logic [CNT_W-1:0]       outstanding_o,
    output logic [15:0]            stall_cnt_o
);

    localparam logic [N_INIT_PORT-1:0] LOCK_ERROR = {N_INIT_PORT{LOCK_ERROR_BIT}};

    ord_state_e             state_q, state_d;
    logic [N_INIT_PORT-1:0] lock_dest_q, lock_dest_d;
    logic [CNT_W-1:0]       cnt;
    logic                   cnt_full, cnt_empty;
    logic                   dest_err, dest_match, may_issue, fwd, issue;
    logic                   ends_zero;

    axi_outstanding_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (issue),
        .dec_i   (r_done_i),
        .cnt_o   (cnt),
        .full_o  (cnt_full),
        .empty_o (cnt_empty)
    );

    // Forwarding decision depends only on state, count and dest_i, so
    // arready_i never feeds back into arvalid_o.
    always_comb begin
        dest_err   = (dest_i == '0);
        dest_match = (dest_i == lock_dest_q);
        case (state_q)
            IDLE:            may_issue = 1'b1;
            ACTIVE:          may_issue = dest_match & ~cnt_full;
            DRAIN, ERR_WAIT: may_issue = cnt_empty;
            default:         may_issue = 1'b0;
        endcase
        // rst_n gating keeps the request outputs quiet while in reset.
        fwd         = rst_n & arvalid_i & may_issue;
        arvalid_o   = {N_INIT_PORT{fwd}} & dest_i;
        error_req_o = fwd & dest_err;
        arready_o   = (|(arvalid_o & arready_i)) | (error_req_o & error_gnt_i);
        issue       = arready_o;
    end

    // Count will be zero after this edge with nothing newly issued.
    assign ends_zero = ~issue & (cnt_empty | ((cnt == CNT_W'(1)) & r_done_i));

    always_comb begin
        state_d     = state_q;
        lock_dest_d = lock_dest_q;
        if (issue) begin
            state_d     = ACTIVE;
            lock_dest_d = dest_err ? LOCK_ERROR : dest_i;
        end else begin
            case (state_q)
                ACTIVE: begin
                    if (arvalid_i && !dest_match) begin
                        state_d = dest_err ? ERR_WAIT : DRAIN;
                    end else if (!arvalid_i && ends_zero) begin
                        state_d = IDLE;
                    end
                end
                DRAIN, ERR_WAIT: begin
                    if (cnt_empty) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lock_dest_q <= '0;
        end else begin
            state_q     <= state_d;
            lock_dest_q <= lock_dest_d;
        end
    end

    assign outstanding_o = cnt;

`ifdef AXI_AR_ORDER_CTRL_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (arvalid_i && !arready_o) begin
            stall_cnt_q <= sat_inc16(stall_cnt_q);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/axi_ar_order_ctrl.md
AXI_AR_ORDER_CTRL -- requirements
Module: axi_ar_order_ctrl

Interface
REQ-001 SHALL have parameter N_INIT_PORT, default 4, number of target-side ports.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 8, maximum in-flight read bursts; CNT_W = $clog2(MAX_OUTSTANDING+1).
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port arvalid_i  input  1  upstream AR valid.
REQ-006 SHALL have port dest_i  input  N_INIT_PORT  one-hot decoded destination; all-zero means decode error.
REQ-007 SHALL have port arready_o  output  1  upstream AR ready.
REQ-008 SHALL have port arvalid_o  output  N_INIT_PORT  per-target AR valid.
REQ-009 SHALL have port arready_i  input  N_INIT_PORT  per-target AR ready.
REQ-010 SHALL have port error_req_o  output  1  request to error responder.
REQ-011 SHALL have port error_gnt_i  input  1  error responder accepts request.
REQ-012 SHALL have port r_done_i  input  1  upstream R beat with rvalid, rready and rlast all high.
REQ-013 SHALL have port outstanding_o  output  CNT_W  current in-flight burst count.
REQ-014 SHALL have port stall_cnt_o  output  16  stall statistics (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, ACTIVE, DRAIN, ERR_WAIT.
REQ-016 In IDLE (count 0), a valid request with non-zero dest_i SHALL drive arvalid_o = dest_i combinationally; on a handshake it SHALL latch lock_dest = dest_i, increment the count and go to ACTIVE.
REQ-017 In IDLE, a request with zero dest_i SHALL assert error_req_o; on error_gnt_i it SHALL assert arready_o, set lock_dest to ERROR, increment the count and go to ACTIVE.
REQ-018 In ACTIVE, a request matching lock_dest with count < MAX_OUTSTANDING SHALL be forwarded as in REQ-016/017.
REQ-019 In ACTIVE, a mismatching request SHALL be stalled (arvalid_o=0, arready_o=0, error_req_o=0) and the FSM SHALL go to DRAIN, or to ERR_WAIT if dest_i is zero.
REQ-020 DRAIN/ERR_WAIT SHALL hold the request stalled until the count reaches 0, then behave as IDLE in that same cycle.
REQ-021 At count == MAX_OUTSTANDING, all forwarding SHALL stall irrespective of destination.
REQ-022 arready_o SHALL equal |(arvalid_o & arready_i) or the granted error handshake; no combinational path from arready_i to arvalid_o.
REQ-023 r_done_i SHALL decrement the count by 1; issue plus r_done_i in the same cycle SHALL leave the count unchanged.
REQ-024 r_done_i at count 0 SHALL be ignored (no underflow).
REQ-025 When the count reaches 0 in ACTIVE with no pending request, the FSM SHALL return to IDLE next cycle.
REQ-026 Once arvalid_i is presented, the FSM SHALL not alter the stall decision until that request is accepted; dest_i is required stable while arvalid_i is high.

Reset
REQ-027 Under rst_n low, state SHALL be IDLE, the count 0, lock_dest 0, stall_cnt_o 0; arvalid_o, arready_o and error_req_o SHALL be 0 while reset is asserted.
REQ-028 Reset mid-burst SHALL discard all outstanding tracking immediately.

Configuration
REQ-029 With macro AXI_AR_ORDER_CTRL_STATS_EN defined, stall_cnt_o SHALL count cycles with arvalid_i high and arready_o low, saturating at 16'hFFFF.
REQ-030 Without AXI_AR_ORDER_CTRL_STATS_EN, stall_cnt_o SHALL be tied to 0 and the counter SHALL not be synthesised.

Structure
REQ-031 The FSM state enum, the ERROR lock_dest encoding and the default MAX_OUTSTANDING SHALL reside in the shared package axi_order_pkg.
REQ-032 The count SHALL be one sub-module, axi_outstanding_counter (inc, dec, full, empty).

Verification
REQ-033 IDLE, dest_i=4'b0010, arready_i=4'b0010 -> arvalid_o=4'b0010, arready_o=1 the same cycle, outstanding_o=1.
REQ-034 Two bursts to port 1 outstanding, then request to port 2 -> stalled; after two r_done_i pulses, forwarded in the cycle the count reaches 0.
REQ-035 MAX_OUTSTANDING=8, 8 issues to port 0 without completion -> 9th stalled; one r_done_i -> 9th accepted, count stays 8.
REQ-036 One outstanding to port 3, request with dest_i=0 -> ERR_WAIT, error_req_o=0; after r_done_i -> error_req_o=1; error_gnt_i -> arready_o=1, count 1.
REQ-037 Issue and r_done_i in the same cycle at count 3 -> count 3; r_done_i at count 0 -> count 0.
REQ-038 rst_n low with count 5 in ACTIVE -> IDLE, count 0, outputs 0; with STATS_EN, 10 stalled cycles -> stall_cnt_o=10.
